// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall levels, jump-info bit positions and FSM encoding for
// the pipeline stall/flush controller and its helpers.
package pipe_ctrl_pkg;

    localparam int RAMAddrLen    = 32;
    localparam int StallLevelLen = 2;
    localparam int JumpInfoLen   = 2;
    localparam int FsmLen        = 1;

    localparam logic [StallLevelLen-1:0] Stall_Null   = 2'd0;
    localparam logic [StallLevelLen-1:0] Stall_Decode = 2'd1;
    localparam logic [StallLevelLen-1:0] Stall_Issue  = 2'd2;
    localparam logic [StallLevelLen-1:0] Stall_All    = 2'd3;

    localparam int Jump_ID = 0;
    localparam int Jump_EX = 1;

    localparam logic                  Enable   = 1'b1;
    localparam logic [RAMAddrLen-1:0] ZeroWord = '0;

    localparam logic [FsmLen-1:0] S_RUN  = 1'b0;
    localparam logic [FsmLen-1:0] S_HOLD = 1'b1;

endpackage

// File: rtl/pipe_ctrl_jump_pend_buf.sv
// One pending-jump slot: holds the first jump captured while the pipeline is
// frozen until the controller replays it. Clear has priority over capture.
module jump_pend_buf
    import pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  clear,
    input  logic [RAMAddrLen-1:0] target,
    output logic                  pend,
    output logic [RAMAddrLen-1:0] pend_pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= 1'b0;
            pend_pc <= ZeroWord;
        end else if (clear) begin
            pend    <= 1'b0;
        end else if (capture && !pend) begin
            pend    <= Enable;
            pend_pc <= target;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller: arbitrates stage stall requests against ID/EX jump
// resolutions and replays jumps that resolved while the pipeline was frozen.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_stall_req,
    input  logic                     id_loaduse_req,
    input  logic                     mem_busy,
    input  logic                     jump_id_req,
    input  logic [RAMAddrLen-1:0]    jump_id_target,
    input  logic                     jump_ex_req,
    input  logic [RAMAddrLen-1:0]    jump_ex_target,
    output logic [StallLevelLen-1:0] stall_command,
    output logic [JumpInfoLen-1:0]   jp,
    output logic                     redirect_valid,
    output logic [RAMAddrLen-1:0]    redirect_pc,
    output logic                     mem_timeout,
    output logic [31:0]              cnt_stall_all,
    output logic [31:0]              cnt_flush
);

    localparam int               BusyW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BusyW-1:0] BusyMax  = BusyW'(MEM_TIMEOUT);
    localparam logic [BusyW-1:0] BusyLast = BusyW'(MEM_TIMEOUT - 1);

    logic [FsmLen-1:0]     state;
    logic [FsmLen-1:0]     state_next;
    logic [BusyW-1:0]      busy_cnt;
    logic                  pend_ex;
    logic                  pend_id;
    logic [RAMAddrLen-1:0] pend_ex_pc;
    logic [RAMAddrLen-1:0] pend_id_pc;
    logic                  hold;
    logic                  ex_any;
    logic                  id_any;
    logic                  fire_ex;
    logic                  fire_id;
    logic                  cap_ex;
    logic                  cap_id;

    assign hold       = (state == S_HOLD);
    assign state_next = mem_busy ? S_HOLD : S_RUN;
    assign ex_any     = pend_ex || jump_ex_req;
    assign id_any     = pend_id || jump_id_req;

    // Only jumps seen after the first frozen cycle are held; an ID jump
    // yields to any EX jump, pending or live, since EX flushes it anyway.
    assign cap_ex = mem_busy && hold && jump_ex_req;
    assign cap_id = mem_busy && hold && jump_id_req && !jump_ex_req && !pend_ex;

    // NOTE: every combinational output gets a default first so no path
    // through the priority chain can infer a latch.
    always_comb begin
        stall_command  = Stall_Null;
        jp             = '0;
        redirect_valid = 1'b0;
        redirect_pc    = ZeroWord;
        fire_ex        = 1'b0;
        fire_id        = 1'b0;
        if (rst) begin
            if (mem_busy) begin
                stall_command = Stall_All;
            end else if (ex_any) begin
                fire_ex        = Enable;
                jp[Jump_EX]    = Enable;
                redirect_valid = Enable;
                redirect_pc    = pend_ex ? pend_ex_pc : jump_ex_target;
            end else if (id_loaduse_req) begin
                stall_command = Stall_Issue;
            end else if (id_any) begin
                fire_id        = Enable;
                jp[Jump_ID]    = Enable;
                redirect_valid = Enable;
                redirect_pc    = pend_id ? pend_id_pc : jump_id_target;
            end else if (if_stall_req) begin
                stall_command = Stall_Decode;
            end
        end
    end

    jump_pend_buf u_pend_ex (
        .clk     (clk),
        .rst     (rst),
        .capture (cap_ex),
        .clear   (fire_ex),
        .target  (jump_ex_target),
        .pend    (pend_ex),
        .pend_pc (pend_ex_pc)
    );

    jump_pend_buf u_pend_id (
        .clk     (clk),
        .rst     (rst),
        .capture (cap_id),
        .clear   (fire_ex || fire_id),
        .target  (jump_id_target),
        .pend    (pend_id),
        .pend_pc (pend_id_pc)
    );

    // Counters key off mem_busy and the fire strobes, never off their own
    // values, so nothing here feeds back into stall_command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_RUN;
            busy_cnt      <= '0;
            mem_timeout   <= 1'b0;
            cnt_stall_all <= '0;
            cnt_flush     <= '0;
        end else begin
            state <= state_next;
            if (!mem_busy) begin
                busy_cnt <= '0;
            end else if (busy_cnt != BusyMax) begin
                busy_cnt <= busy_cnt + BusyW'(1);
            end
            if (mem_busy && (busy_cnt >= BusyLast)) begin
                mem_timeout <= Enable;
            end
            if (mem_busy) begin
                cnt_stall_all <= cnt_stall_all + 32'd1;
            end
            if (fire_ex || fire_id) begin
                cnt_flush <= cnt_flush + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops and compares them.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_stall_req = 1'b0;
    logic        id_loaduse_req = 1'b0;
    logic        mem_busy = 1'b0;
    logic        jump_id_req = 1'b0;
    logic [31:0] jump_id_target = '0;
    logic        jump_ex_req = 1'b0;
    logic [31:0] jump_ex_target = '0;
    logic [1:0]  stall_command;
    logic [1:0]  jp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_timeout;
    logic [31:0] cnt_stall_all;
    logic [31:0] cnt_flush;

    pipe_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall_req   (if_stall_req),
        .id_loaduse_req (id_loaduse_req),
        .mem_busy       (mem_busy),
        .jump_id_req    (jump_id_req),
        .jump_id_target (jump_id_target),
        .jump_ex_req    (jump_ex_req),
        .jump_ex_target (jump_ex_target),
        .stall_command  (stall_command),
        .jp             (jp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_timeout    (mem_timeout),
        .cnt_stall_all  (cnt_stall_all),
        .cnt_flush      (cnt_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  stall;
        logic [1:0]  jp;
        logic        rv;
        logic        chk_pc;
        logic [31:0] pc;
        logic        mt;
        logic [31:0] csa;
        logic [31:0] cf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: held jumps as queues of targets, busy run length as a
    // plain integer, frozen-last-cycle as a bit.
    logic [31:0] m_ex[$];
    logic [31:0] m_id[$];
    bit          m_frozen;
    int          m_run;
    bit          m_to;
    logic [31:0] m_csa;
    logic [31:0] m_cf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ex.delete();
        m_id.delete();
        m_frozen = 1'b0;
        m_run    = 0;
        m_to     = 1'b0;
        m_csa    = '0;
        m_cf     = '0;
    endtask

    task automatic cycle(input bit ifs, input bit lu, input bit mb,
                         input bit jid, input logic [31:0] tid,
                         input bit jex, input logic [31:0] tex);
        exp_t e;
        bit   have_ex;
        bit   have_id;
        if_stall_req   = ifs;
        id_loaduse_req = lu;
        mem_busy       = mb;
        jump_id_req    = jid;
        jump_id_target = tid;
        jump_ex_req    = jex;
        jump_ex_target = tex;
        have_ex = (m_ex.size() > 0);
        have_id = (m_id.size() > 0);
        e.stall = Stall_Null;
        e.jp    = 2'b00;
        e.rv    = 1'b0;
        e.pc    = '0;
        if (mb) begin
            e.stall = Stall_All;
        end else if (have_ex || jex) begin
            e.jp = 2'b10;
            e.rv = 1'b1;
            e.pc = have_ex ? m_ex[0] : tex;
        end else if (lu) begin
            e.stall = Stall_Issue;
        end else if (have_id || jid) begin
            e.jp = 2'b01;
            e.rv = 1'b1;
            e.pc = have_id ? m_id[0] : tid;
        end else if (ifs) begin
            e.stall = Stall_Decode;
        end
        e.chk_pc = e.rv;
        e.mt     = m_to;
        e.csa    = m_csa;
        e.cf     = m_cf;
        sb.push_back(e);

        if (mb) begin
            if (m_frozen) begin
                if (!have_ex && jex) m_ex.push_back(tex);
                if (jid && !have_ex && !jex && !have_id) m_id.push_back(tid);
            end
        end else if (e.jp == 2'b10) begin
            m_ex.delete();
            m_id.delete();
        end else if (e.jp == 2'b01) begin
            m_id.delete();
        end
        m_frozen = mb;
        m_run    = mb ? m_run + 1 : 0;
        if (m_run >= MT) m_to = 1'b1;
        if (e.stall == Stall_All) m_csa = m_csa + 32'd1;
        if (e.jp != 2'b00) m_cf = m_cf + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit mb, input bit jex, input logic [31:0] tex);
        exp_t e;
        rst            = 1'b0;
        if_stall_req   = 1'b0;
        id_loaduse_req = 1'b0;
        mem_busy       = mb;
        jump_id_req    = 1'b0;
        jump_ex_req    = jex;
        jump_ex_target = tex;
        model_reset();
        e.stall  = Stall_Null;
        e.jp     = 2'b00;
        e.rv     = 1'b0;
        e.chk_pc = 1'b1;
        e.pc     = '0;
        e.mt     = 1'b0;
        e.csa    = '0;
        e.cf     = '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall_command", 32'(stall_command), 32'(e.stall));
            check("jp", 32'(jp), 32'(e.jp));
            check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            if (e.chk_pc) check("redirect_pc", redirect_pc, e.pc);
            check("mem_timeout", 32'(mem_timeout), 32'(e.mt));
            check("cnt_stall_all", cnt_stall_all, e.csa);
            check("cnt_flush", cnt_flush, e.cf);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit mb_run;
        model_reset();
        @(posedge clk);
        #1;

        // Load-use stall then idle.
        do_reset(1'b0, 1'b0, '0);
        cycle(0, 0, 0, 0, '0, 0, '0);
        cycle(0, 1, 0, 0, '0, 0, '0);
        cycle(0, 1, 0, 0, '0, 0, '0);
        cycle(0, 0, 0, 0, '0, 0, '0);
        // Simultaneous EX and ID jumps: EX wins.
        cycle(0, 0, 0, 1, 32'h2000, 1, 32'h1000);
        cycle(0, 0, 0, 0, '0, 0, '0);
        // EX jump during HOLD is replayed on release.
        do_reset(1'b0, 1'b0, '0);
        cycle(0, 0, 1, 0, '0, 0, '0);
        cycle(0, 0, 1, 0, '0, 1, 32'h0040);
        cycle(0, 0, 1, 0, '0, 0, '0);
        cycle(0, 0, 0, 0, '0, 0, '0);
        cycle(0, 0, 0, 0, '0, 0, '0);
        // Load-use suppresses ID jump until the next cycle.
        cycle(0, 1, 0, 1, 32'h2000, 0, '0);
        cycle(0, 0, 0, 1, 32'h2000, 0, '0);
        cycle(1, 0, 0, 0, '0, 0, '0);
        // Single-cycle busy pulse.
        cycle(1, 0, 1, 0, '0, 0, '0);
        cycle(1, 0, 0, 0, '0, 0, '0);
        // Timeout after MT busy cycles, sticky afterwards.
        do_reset(1'b0, 1'b0, '0);
        repeat (6) cycle(0, 0, 1, 0, '0, 0, '0);
        repeat (2) cycle(0, 0, 0, 0, '0, 0, '0);
        // Reset mid-HOLD discards the pending EX jump.
        do_reset(1'b0, 1'b0, '0);
        cycle(0, 0, 1, 0, '0, 0, '0);
        cycle(0, 0, 1, 0, '0, 1, 32'h0080);
        cycle(0, 0, 1, 0, '0, 0, '0);
        do_reset(1'b1, 1'b1, 32'h0099);
        cycle(0, 0, 0, 0, '0, 0, '0);
        cycle(0, 0, 0, 0, '0, 0, '0);

        // Randomized traffic with busy bursts and occasional resets.
        mb_run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                mb_run = 1'b0;
            end else begin
                mb_run = mb_run ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, mb_run,
                      $urandom_range(0, 3) == 0, $urandom,
                      $urandom_range(0, 4) == 0, $urandom);
            end
        end
        cycle(0, 0, 0, 0, '0, 0, '0);

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
